// File: rtl/pe_mac_sa.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pe_mac_sa                                                        |
// | Brief   : Weight-stationary MAC processing element with a local weight     |
// |           bank, saturating accumulation and systolic pass-through.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pe_mac_sa #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 20,
  parameter int WBUF_DEPTH = 4,
  parameter bit SIGNED     = 1'b0,
  localparam int SEL_W     = $clog2(WBUF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              activate,
  input  logic [1:0]        mode_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] pe_in,
  input  logic              pe_in_vld,
  input  logic [DATA_W-1:0] pe_filter,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic [SEL_W-1:0]  w_sel,
  output logic [DATA_W-1:0] pe_in_o,
  output logic              pe_in_vld_o,
  output logic [ACC_W-1:0]  pe_out,
  output logic              pe_out_vld,
  output logic              sat_o,
  output logic [SEL_W:0]    w_cnt_o
);

  localparam int       c_PROD_W      = 2 * DATA_W;
  localparam logic [1:0] c_MODE_SINGLE = 2'd0;
  localparam logic [1:0] c_MODE_LOAD   = 2'd1;
  localparam logic [1:0] c_MODE_SA     = 2'd2;

  logic [DATA_W-1:0] r_wbuf [WBUF_DEPTH];
  logic [ACC_W-1:0]  r_acc;
  logic [SEL_W-1:0]  r_wr_ptr;
  logic [1:0]        r_prev_mode;

  logic [ACC_W-1:0]  w_prod_f;
  logic [ACC_W-1:0]  w_prod_w;
  logic [ACC_W-1:0]  w_acc_base;
  logic [ACC_W:0]    w_single;
  logic [ACC_W:0]    w_sa;
  logic [SEL_W-1:0]  w_load_ptr;
  logic [SEL_W:0]    w_cnt_next;

  // Full-precision product, extended to the accumulator width.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [c_PROD_W-1:0] ea;
    logic [c_PROD_W-1:0] eb;
    logic [c_PROD_W-1:0] p;
    if (SIGNED) begin
      ea = c_PROD_W'($signed(a));
      eb = c_PROD_W'($signed(b));
    end else begin
      ea = c_PROD_W'(a);
      eb = c_PROD_W'(b);
    end
    p = ea * eb;
    if (SIGNED) return ACC_W'($signed(p));
    else        return ACC_W'(p);
  endfunction

  // Returns {overflow, clamped sum}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    if (SIGNED) begin
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      if (s[ACC_W] != s[ACC_W-1]) return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
      else                         return {1'b0, s[ACC_W-1:0]};
    end else begin
      s = {1'b0, a} + {1'b0, b};
      if (s[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
      else          return {1'b0, s[ACC_W-1:0]};
    end
  endfunction

  always_comb begin
    w_prod_f   = mul_ext(pe_in, pe_filter);
    w_prod_w   = mul_ext(pe_in, r_wbuf[w_sel]);
    w_acc_base = clr_i ? '0 : r_acc;
    w_single   = sat_add(w_acc_base, w_prod_f);
    w_sa       = sat_add(psum_in, w_prod_w);
    // A LOAD burst entered from any other mode restarts at entry 0.
    w_load_ptr = (r_prev_mode == c_MODE_LOAD) ? r_wr_ptr : '0;
    w_cnt_next = {1'b0, w_load_ptr} + (SEL_W + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WBUF_DEPTH; i++) r_wbuf[i] <= '0;
      r_acc       <= '0;
      r_wr_ptr    <= '0;
      r_prev_mode <= c_MODE_SINGLE;
      pe_in_o     <= '0;
      pe_in_vld_o <= 1'b0;
      pe_out      <= '0;
      pe_out_vld  <= 1'b0;
      sat_o       <= 1'b0;
      w_cnt_o     <= '0;
    end else if (!activate) begin
      pe_out_vld  <= 1'b0;
      pe_in_vld_o <= 1'b0;
    end else begin
      r_prev_mode <= mode_i;
      pe_out_vld  <= 1'b0;
      pe_in_vld_o <= 1'b0;
      if (clr_i) begin
        r_acc <= '0;
        sat_o <= 1'b0;
      end
      case (mode_i)
        c_MODE_SINGLE: begin
          if (pe_in_vld) begin
            r_acc      <= w_single[ACC_W-1:0];
            pe_out     <= w_single[ACC_W-1:0];
            pe_out_vld <= 1'b1;
            sat_o      <= (sat_o & ~clr_i) | w_single[ACC_W];
          end
        end
        c_MODE_LOAD: begin
          r_wbuf[w_load_ptr] <= pe_filter;
          r_wr_ptr           <= w_load_ptr + SEL_W'(1);
          // Distinct entries written so far; bursts always fill from entry 0.
          if (w_cnt_next > w_cnt_o) w_cnt_o <= w_cnt_next;
        end
        c_MODE_SA: begin
          pe_in_o     <= pe_in;
          pe_in_vld_o <= pe_in_vld;
          if (pe_in_vld) begin
            pe_out     <= w_sa[ACC_W-1:0];
            pe_out_vld <= 1'b1;
            sat_o      <= (sat_o & ~clr_i) | w_sa[ACC_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
